data_ram_arbiter: RTL
=====================

Name: data_ram_arbiter

Overview:
- Two-port round-robin arbiter and access sequencer in front of the single-port data RAM.
- Data RAM: word-addressed, combinational read, write on falling clock edge when write-enable is high.
- Requester 0 is the CPU load/store stage. Requester 1 is the debug/DMA loader.
- The block serialises their valid/ready requests into one RAM access each, and returns read data or write completion on a per-port response strobe.

Parameters:
- ADDRESS_SIZE, 32, width of request and RAM address buses.
- DATA_SIZE, 32, width of data buses.
- TOTAL_RAM_SIZE, 256, number of RAM words; addresses >= this are out of range.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  port 0 request present.
- req0_we  in  1  port 0 write (1) / read (0).
- req0_addr  in  ADDRESS_SIZE  port 0 word address.
- req0_wdata  in  DATA_SIZE  port 0 write data.
- req0_ready  out  1  port 0 request accepted this cycle.
- resp0_valid  out  1  port 0 response strobe.
- resp0_rdata  out  DATA_SIZE  port 0 read data.
- resp0_err  out  1  port 0 address out of range.
- req1_valid, req1_we, req1_addr, req1_wdata, req1_ready, resp1_valid, resp1_rdata, resp1_err: same as port 0, for port 1.
- ram_addr  out  ADDRESS_SIZE  to RAM address input.
- ram_wdata  out  DATA_SIZE  to RAM write-data input.
- ram_w_enable  out  1  to RAM write enable.
- ram_rdata  in  DATA_SIZE  from RAM read-data output.

Behaviour:
- Reset (asynchronous, rst_n low):
  - State goes to IDLE and the priority pointer to port 0.
  - All latched request fields and response data are cleared.
  - Every output reads 0, including ram_w_enable, while rst_n is low.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - The winner is chosen combinationally from the valid ports.
  - If only one port is valid, it wins.
  - If both are valid, the port named by the pointer wins.
  - The winner's reqN_ready = 1 in the same cycle; the loser's ready = 0.
  - On the rising edge with valid & ready, latch we/addr/wdata and the winner id, toggle the pointer to the other port, and go to ACCESS.
  - With no valid port, stay in IDLE; the pointer is unchanged.
- ACCESS (exactly 1 cycle):
  - ram_addr = latched addr and ram_wdata = latched wdata.
  - ram_w_enable = latched we AND address in range. The RAM therefore commits the write on this cycle's falling edge.
  - At the rising edge, capture ram_rdata into the response register (reads only), then go to RESP.
- RESP (exactly 1 cycle):
  - respN_valid = 1 for the latched winner only.
  - rdata = captured data for reads; 0 for writes and out-of-range accesses.
  - err = 1 if the address is >= TOTAL_RAM_SIZE.
  - Then go to IDLE.
- Outside ACCESS: ram_addr = 0, ram_wdata = 0, ram_w_enable = 0.
- Ready is 0 in ACCESS and RESP.
- Latency: accept at edge N, response visible in cycle N+2. Maximum throughput is one access per 3 cycles.
- Out-of-range address: no RAM write, rdata = 0, err = 1. The RAM is never driven with an out-of-range address (ram_addr forced to 0).
- Fairness under constant contention: grants alternate 0,1,0,1. No port waits more than one other access.
- Requester holds valid/we/addr/wdata stable until ready.
  - Changes while not ready are ignored.
  - Dropping valid before ready withdraws the request with no side effect.
- Reset asserted during ACCESS: ram_w_enable drops immediately. If this happens before the falling edge, the write is suppressed. No response is issued for the aborted access.
- Reset deassertion: the first grant goes to port 0 if both ports are valid.

Test Plan:
- Reset, then port 0 writes 0xDEADBEEF to address 5 while port 1 is idle → req0_ready high in that cycle; ram_w_enable high for exactly one cycle with ram_addr 5; resp0_valid pulse 2 cycles after accept with rdata 0 and err 0.
- Port 1 reads address 5 after the above → resp1_valid with resp1_rdata 0xDEADBEEF and resp1_err 0; resp0_valid stays 0.
- Both ports hold valid reads of addresses 1 and 2 for 12 cycles → grants strictly alternate 0,1,0,1 starting with port 0; 4 responses total, each 3 cycles apart.
- Port 0 writes 0x1 to address 300 (TOTAL_RAM_SIZE 256) → ram_w_enable never asserted; resp0_err 1 and rdata 0; a later read of address 44 (300 mod 256) is unchanged.
- Assert rst_n low mid-ACCESS of a write to address 7, before the falling edge → all outputs 0 immediately; no response issued; a later read of address 7 returns its prior value.
- Port 1 drops valid after 2 cycles of waiting behind a port-0 access → no grant to port 1; pointer unchanged for port 1's withdrawn request; the next lone port-0 request is accepted normally.

Source files
------------

// File: rtl/data_ram_arbiter.sv
// Two-port round-robin arbiter and access sequencer in front of the single-port data RAM.
// Port 0 is the CPU load/store stage, port 1 the debug/DMA loader. Each accepted request
// becomes one RAM access (ACCESS cycle) followed by a one-cycle response strobe (RESP).
module data_ram_arbiter #(
    parameter int unsigned ADDRESS_SIZE   = 32,
    parameter int unsigned DATA_SIZE      = 32,
    parameter int unsigned TOTAL_RAM_SIZE = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    req0_valid,
    input  logic                    req0_we,
    input  logic [ADDRESS_SIZE-1:0] req0_addr,
    input  logic [DATA_SIZE-1:0]    req0_wdata,
    output logic                    req0_ready,
    output logic                    resp0_valid,
    output logic [DATA_SIZE-1:0]    resp0_rdata,
    output logic                    resp0_err,

    input  logic                    req1_valid,
    input  logic                    req1_we,
    input  logic [ADDRESS_SIZE-1:0] req1_addr,
    input  logic [DATA_SIZE-1:0]    req1_wdata,
    output logic                    req1_ready,
    output logic                    resp1_valid,
    output logic [DATA_SIZE-1:0]    resp1_rdata,
    output logic                    resp1_err,

    output logic [ADDRESS_SIZE-1:0] ram_addr,
    output logic [DATA_SIZE-1:0]    ram_wdata,
    output logic                    ram_w_enable,
    input  logic [DATA_SIZE-1:0]    ram_rdata
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    // One extra bit so the limit is representable even when it equals 2**ADDRESS_SIZE.
    localparam logic [ADDRESS_SIZE:0] RamLimit = (ADDRESS_SIZE + 1)'(TOTAL_RAM_SIZE);

    state_e                  state_q, state_d;
    logic                    ptr_q, ptr_d;      // port that wins when both are valid
    logic                    owner_q, owner_d;  // port being served
    logic                    we_q, we_d;
    logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
    logic [DATA_SIZE-1:0]    wdata_q, wdata_d;
    logic [DATA_SIZE-1:0]    rdata_q, rdata_d;

    logic grant0, grant1, in_range;

    assign in_range = ({1'b0, addr_q} < RamLimit);

    // Combinational winner selection; only meaningful while idle.
    always_comb begin
        grant0 = (state_q == StIdle) && req0_valid && (!req1_valid || !ptr_q);
        grant1 = (state_q == StIdle) && req1_valid && (!req0_valid ||  ptr_q);
    end

    // State and latched request/response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= 1'b0;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state: accept a winner in IDLE, capture read data at the end of ACCESS.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (grant0 || grant1) begin
                    owner_d = grant1;
                    we_d    = grant1 ? req1_we    : req0_we;
                    addr_d  = grant1 ? req1_addr  : req0_addr;
                    wdata_d = grant1 ? req1_wdata : req0_wdata;
                    // Priority moves to the port that just lost (or was absent).
                    ptr_d   = ~grant1;
                    state_d = StAccess;
                end
            end
            StAccess: begin
                rdata_d = (!we_q && in_range) ? ram_rdata : '0;
                state_d = StResp;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs: RAM drive only in ACCESS, response strobe only in RESP.
    always_comb begin
        req0_ready   = grant0 && rst_n;
        req1_ready   = grant1 && rst_n;
        resp0_valid  = 1'b0;
        resp1_valid  = 1'b0;
        resp0_rdata  = '0;
        resp1_rdata  = '0;
        resp0_err    = 1'b0;
        resp1_err    = 1'b0;
        ram_addr     = '0;
        ram_wdata    = '0;
        ram_w_enable = 1'b0;
        unique case (state_q)
            StAccess: begin
                ram_addr     = in_range ? addr_q : '0;
                ram_wdata    = wdata_q;
                ram_w_enable = we_q && in_range;
            end
            StResp: begin
                if (owner_q) begin
                    resp1_valid = 1'b1;
                    resp1_rdata = rdata_q;
                    resp1_err   = !in_range;
                end else begin
                    resp0_valid = 1'b1;
                    resp0_rdata = rdata_q;
                    resp0_err   = !in_range;
                end
            end
            default: begin
            end
        endcase
    end

endmodule
